// File: rtl/bank_cmd_scheduler.sv
// bank_cmd_scheduler: picks one per-bank request per cycle and issues it on a
// single registered valid/ready command channel. Requests are grouped into
// read and write bursts, and a fixed turnaround gap separates direction changes.
// Optional: define ROW_HIT_PRIO_EN to track the last granted row per bank and
// favour requests that hit it. NB must be a power of two so the round-robin
// pointer wraps by natural overflow.

`ifdef ROW_HIT_PRIO_EN
module bank_row_lane #(
  parameter int RA = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gnt_i,
  input  logic [RA-1:0] ra_i,
  output logic          hit_o
);
  logic [RA-1:0] row_q;
  logic          vld_q;

  // Remember the row of the most recent grant to this bank
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      vld_q <= 1'b0;
    end else if (gnt_i) begin
      row_q <= ra_i;
      vld_q <= 1'b1;
    end
  end

  assign hit_o = vld_q && (ra_i == row_q);
endmodule
`endif

module bank_cmd_scheduler #(
  parameter int   NB        = 16,
  parameter int   DQ        = 16,
  parameter int   IDX       = 6,
  parameter int   RA        = 16,
  parameter int   CA        = 10,
  parameter logic READ      = 1'b0,
  parameter logic WRITE     = 1'b1,
  parameter int   WR_HIGH   = 4,
  parameter int   BURST_MAX = 8,
  parameter int   TURN_CYC  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NB-1:0]            valid_i,
  input  logic [NB-1:0]            t_i,
  input  logic [NB-1:0][DQ-1:0]    dq_i,
  input  logic [NB-1:0][IDX-1:0]   idx_i,
  input  logic [NB-1:0][RA-1:0]    ra_i,
  input  logic [NB-1:0][CA-1:0]    ca_i,
  output logic [NB-1:0]            ready_o,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [$clog2(NB)-1:0]    cmd_bank_o,
  output logic                     cmd_t_o,
  output logic [DQ-1:0]            cmd_dq_o,
  output logic [IDX-1:0]           cmd_idx_o,
  output logic [RA-1:0]            cmd_ra_o,
  output logic [CA-1:0]            cmd_ca_o,
  output logic                     mode_o
);
  localparam int BW  = $clog2(NB);
  localparam int CW  = $clog2(NB + 1);
  localparam int BCW = $clog2(BURST_MAX + 1);
  localparam int TCW = $clog2(TURN_CYC + 1);

  localparam logic [CW-1:0]  WR_HIGH_C   = CW'(WR_HIGH);
  localparam logic [BCW-1:0] BURST_MAX_C = BCW'(BURST_MAX);
  localparam logic [TCW-1:0] TURN_LOAD   = TCW'(TURN_CYC - 1);

  typedef enum logic [1:0] {RD, TURN_W, WR, TURN_R} state_e;

  typedef struct packed {
    logic [BW-1:0]  bank;
    logic           t;
    logic [DQ-1:0]  dq;
    logic [IDX-1:0] idx;
    logic [RA-1:0]  ra;
    logic [CA-1:0]  ca;
  } cmd_t;

  state_e         state_q, state_d;
  logic [BW-1:0]  ptr_q, ptr_d;
  logic [BCW-1:0] burst_q, burst_d;
  logic [TCW-1:0] turn_q, turn_d;
  logic           cmd_vld_q, cmd_vld_d;
  cmd_t           cmd_q, cmd_d;

  logic [NB-1:0]  rd_req, wr_req, cur_req, search;
  logic [CW-1:0]  nrd, nwr;
  logic           to_w, to_r, slot_free, dir_ok, gnt_en, leave;
  logic           gnt_found;
  logic [BW-1:0]  gnt_bank, cand;
  cmd_t           sel;

  // Per-bank direction split
  for (genvar b = 0; b < NB; b++) begin : g_req
    assign rd_req[b] = valid_i[b] && (t_i[b] == READ);
    assign wr_req[b] = valid_i[b] && (t_i[b] == WRITE);
  end

  // Pending counts per direction drive the mode-switch decisions
  always_comb begin
    nrd = '0;
    nwr = '0;
    for (int b = 0; b < NB; b++) begin
      nrd = nrd + CW'(rd_req[b]);
      nwr = nwr + CW'(wr_req[b]);
    end
  end

  assign to_w = (nwr >= WR_HIGH_C) ||
                ((nrd == '0) && (nwr != '0)) ||
                ((burst_q == BURST_MAX_C) && (nwr != '0));
  assign to_r = ((nwr == '0) && (nrd != '0)) ||
                ((burst_q == BURST_MAX_C) && (nrd != '0) && (nwr < WR_HIGH_C));

  assign cur_req = (state_q == WR) ? wr_req : rd_req;

`ifdef ROW_HIT_PRIO_EN
  logic [NB-1:0] row_hit, hit_req;

  bank_row_lane #(.RA(RA)) u_lane [NB-1:0] (
    .clk   (clk),
    .rst   (rst),
    .gnt_i (ready_o),
    .ra_i  (ra_i),
    .hit_o (row_hit)
  );

  assign hit_req = cur_req & row_hit;
  assign search  = (hit_req != '0) ? hit_req : cur_req;
`else
  assign search = cur_req;
`endif

  // Round-robin: first candidate at or above the pointer, wrapping at NB
  always_comb begin
    gnt_found = 1'b0;
    gnt_bank  = '0;
    cand      = '0;
    for (int i = 0; i < NB; i++) begin
      cand = ptr_q + BW'(i);
      if (!gnt_found && search[cand]) begin
        gnt_found = 1'b1;
        gnt_bank  = cand;
      end
    end
  end

  // A grant needs a free output slot and a cycle in which the FSM stays put
  assign slot_free = !cmd_vld_q || cmd_ready_i;
  assign dir_ok    = ((state_q == RD) && !to_w) || ((state_q == WR) && !to_r);
  assign gnt_en    = !rst && slot_free && dir_ok && gnt_found;
  assign ready_o   = gnt_en ? (NB'(1) << gnt_bank) : '0;

  // Gather the granted bank's fields
  always_comb begin
    sel      = '0;
    sel.bank = gnt_bank;
    sel.t    = t_i[gnt_bank];
    sel.dq   = dq_i[gnt_bank];
    sel.idx  = idx_i[gnt_bank];
    sel.ra   = ra_i[gnt_bank];
    sel.ca   = ca_i[gnt_bank];
  end

  // Direction FSM, turnaround countdown and burst accounting
  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    burst_d = burst_q;
    leave   = 1'b0;
    case (state_q)
      RD: if (to_w) begin
        state_d = TURN_W;
        leave   = 1'b1;
      end
      WR: if (to_r) begin
        state_d = TURN_R;
        leave   = 1'b1;
      end
      TURN_W, TURN_R: begin
        // The gap only starts counting once the last command has drained
        if (!cmd_vld_q) begin
          if (turn_q == '0) state_d = (state_q == TURN_W) ? WR : RD;
          else              turn_d  = turn_q - TCW'(1);
        end
      end
      default: state_d = RD;
    endcase
    if (leave) begin
      turn_d  = TURN_LOAD;
      burst_d = '0;
    end else if (gnt_en && (burst_q != BURST_MAX_C)) begin
      burst_d = burst_q + BCW'(1);
    end
  end

  // Command slot: load on grant, hold under backpressure, clear on accept
  always_comb begin
    cmd_vld_d = cmd_vld_q;
    cmd_d     = cmd_q;
    ptr_d     = ptr_q;
    if (gnt_en) begin
      cmd_vld_d = 1'b1;
      cmd_d     = sel;
      ptr_d     = gnt_bank + BW'(1);
    end else if (cmd_ready_i) begin
      cmd_vld_d = 1'b0;
    end
  end

  // State registers; reset drops any pending command
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RD;
      ptr_q     <= '0;
      burst_q   <= '0;
      turn_q    <= '0;
      cmd_vld_q <= 1'b0;
      cmd_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      burst_q   <= burst_d;
      turn_q    <= turn_d;
      cmd_vld_q <= cmd_vld_d;
      cmd_q     <= cmd_d;
    end
  end

  assign cmd_valid_o = cmd_vld_q;
  assign cmd_bank_o  = cmd_q.bank;
  assign cmd_t_o     = cmd_q.t;
  assign cmd_dq_o    = cmd_q.dq;
  assign cmd_idx_o   = cmd_q.idx;
  assign cmd_ra_o    = cmd_q.ra;
  assign cmd_ca_o    = cmd_q.ca;
  assign mode_o      = ((state_q == WR) || (state_q == TURN_R)) ? WRITE : READ;
endmodule
